// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: FSM state encodings and register constants shared by the stall unit
package hazard_stall_unit_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_unit_compare.sv
// hazard_compare: flags a used ID source that matches a writing stage's nonzero destination
module hazard_compare
    import hazard_stall_unit_pkg::*;
#(
    parameter int NB_REG_ADDR = 5
) (
    input  logic [NB_REG_ADDR-1:0] rs,
    input  logic [NB_REG_ADDR-1:0] rt,
    input  logic [NB_REG_ADDR-1:0] rd,
    input  logic                   use_rs,
    input  logic                   use_rt,
    input  logic                   en,
    output logic                   hit
);
    assign hit = en & (rd != NB_REG_ADDR'(REG_ZERO))
               & ((use_rs & (rs == rd)) | (use_rt & (rt == rd)));
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and branch-operand stall FSM with IF/ID flush and a stall-cycle counter
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid_id,
    input  logic [NB_REG_ADDR-1:0] i_rs,
    input  logic [NB_REG_ADDR-1:0] i_rt,
    input  logic                   i_rinst,
    input  logic                   i_jinst,
    input  logic                   i_branch,
    input  logic                   i_branch_taken,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_we_ex,
    input  logic                   i_memread_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    input  logic                   i_memread_mem,
    output logic                   o_stall,
    output logic                   o_bubble_ex,
    output logic                   o_flush_id,
    output logic [NB_CNT-1:0]      o_stall_cnt
);
    logic       state, state_nxt;
    logic [1:0] remain, remain_nxt, need;
    logic       use_rs, use_rt, hit_ex, hit_mem, ld_ex, alu_ex, ld_mem;

    assign use_rs = i_valid_id & ~i_jinst;
    assign use_rt = use_rs & (i_rinst | i_branch);

    hazard_compare #(.NB_REG_ADDR(NB_REG_ADDR)) u_cmp_ex (
        .rs(i_rs), .rt(i_rt), .rd(i_rd_ex), .use_rs(use_rs), .use_rt(use_rt),
        .en(i_we_ex | i_memread_ex), .hit(hit_ex)
    );

    hazard_compare #(.NB_REG_ADDR(NB_REG_ADDR)) u_cmp_mem (
        .rs(i_rs), .rt(i_rt), .rd(i_rd_mem), .use_rs(use_rs), .use_rt(use_rt),
        .en(i_memread_mem), .hit(hit_mem)
    );

    assign ld_ex  = i_memread_ex & hit_ex;
    assign alu_ex = i_we_ex & ~i_memread_ex & hit_ex;
    assign ld_mem = hit_mem;

    // Branches compare in ID, so even ALU results and MEM loads are too late to bypass
    always_comb begin
        need       = (i_branch & ld_ex) ? 2'd2
                   : (ld_ex | (i_branch & (alu_ex | ld_mem))) ? 2'd1 : 2'd0;
        state_nxt  = (state == ST_IDLE) ? ((need > 2'd1) ? ST_STALL : ST_IDLE)
                                        : ((remain > 2'd1) ? ST_STALL : ST_IDLE);
        remain_nxt = (state == ST_IDLE) ? ((need > 2'd1) ? need - 2'd1 : 2'd0)
                                        : ((remain != 2'd0) ? remain - 2'd1 : 2'd0);
        o_stall    = ~i_reset & ((state == ST_STALL) ? (remain != 2'd0) : (need != 2'd0));
        o_bubble_ex = o_stall;
        o_flush_id = ~i_reset & i_branch_taken & ~o_stall;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            remain      <= 2'd0;
            o_stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            if (o_stall && !(&o_stall_cnt))
                o_stall_cnt <= o_stall_cnt + NB_CNT'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed pipeline scenarios with hand-computed stall/flush/counter values
module tb_hazard_stall_unit;
    logic       clk = 1'b0;
    logic       rst, valid_id, rinst, jinst, branch, taken, we_ex, memread_ex, memread_mem;
    logic [4:0] rs, rt, rd_ex, rd_mem;
    logic       stall, bubble, flush, sat_stall, sat_bubble, sat_flush;
    logic [31:0] cnt;
    logic [1:0] sat_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .i_clock(clk), .i_reset(rst), .i_valid_id(valid_id), .i_rs(rs), .i_rt(rt),
        .i_rinst(rinst), .i_jinst(jinst), .i_branch(branch), .i_branch_taken(taken),
        .i_rd_ex(rd_ex), .i_we_ex(we_ex), .i_memread_ex(memread_ex),
        .i_rd_mem(rd_mem), .i_memread_mem(memread_mem),
        .o_stall(stall), .o_bubble_ex(bubble), .o_flush_id(flush), .o_stall_cnt(cnt)
    );

    hazard_stall_unit #(.NB_CNT(2)) u_sat (
        .i_clock(clk), .i_reset(rst), .i_valid_id(valid_id), .i_rs(rs), .i_rt(rt),
        .i_rinst(rinst), .i_jinst(jinst), .i_branch(branch), .i_branch_taken(taken),
        .i_rd_ex(rd_ex), .i_we_ex(we_ex), .i_memread_ex(memread_ex),
        .i_rd_mem(rd_mem), .i_memread_mem(memread_mem),
        .o_stall(sat_stall), .o_bubble_ex(sat_bubble), .o_flush_id(sat_flush), .o_stall_cnt(sat_cnt)
    );

    task automatic drive(input logic r, v, input logic [4:0] a, b, input logic ri, ji, br, tk,
                         input logic [4:0] rdx, input logic wex, mrx, input logic [4:0] rdm,
                         input logic mrm);
        rst = r; valid_id = v; rs = a; rt = b; rinst = ri; jinst = ji; branch = br; taken = tk;
        rd_ex = rdx; we_ex = wex; memread_ex = mrx; rd_mem = rdm; memread_mem = mrm;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle's outputs mid-cycle, then moves to just after the next edge
    task automatic step(input string tag, input logic st, input logic fl, input int n);
        #2;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
        chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, st});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
        chk({tag, ".cnt"}, cnt, n);
        chk({tag, ".sat_stall"}, {31'd0, sat_stall}, {31'd0, st});
        chk({tag, ".sat_flush"}, {31'd0, sat_flush}, {31'd0, fl});
        chk({tag, ".sat_cnt"}, {30'd0, sat_cnt}, (n > 3) ? 32'd3 : n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 1, 2, 7, 1, 0, 0, 0, 2, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 1, 2, 7, 1, 0, 1, 1, 2, 1, 1, 0, 0);
        step("reset_cycle", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_reset", 0, 0, 0);
        // lw $2 then add rs=2: single load-use stall
        drive(0, 1, 2, 7, 1, 0, 0, 0, 2, 1, 1, 0, 0);
        step("loaduse_c0", 1, 0, 0);
        drive(0, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 2, 1);
        step("loaduse_c1", 0, 0, 1);
        // lw $3 then beq rs=3: two stalls
        drive(0, 1, 3, 9, 0, 0, 1, 0, 3, 1, 1, 0, 0);
        step("ldbr_c0", 1, 0, 1);
        drive(0, 1, 3, 9, 0, 0, 1, 0, 0, 0, 0, 3, 1);
        step("ldbr_c1", 1, 0, 2);
        drive(0, 1, 3, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("ldbr_c2", 0, 0, 3);
        // add $4 then beq rt=4: one stall; add consumer is forwarded
        drive(0, 1, 1, 4, 0, 0, 1, 0, 4, 1, 0, 0, 0);
        step("alubr_c0", 1, 0, 3);
        drive(0, 1, 1, 4, 0, 0, 1, 0, 0, 0, 0, 4, 0);
        step("alubr_c1", 0, 0, 4);
        drive(0, 1, 1, 4, 1, 0, 0, 0, 4, 1, 0, 0, 0);
        step("alu_fwd", 0, 0, 4);
        drive(0, 1, 1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        step("rt_unused", 0, 0, 4);
        // register zero, J-type and bubble in ID never stall
        drive(0, 1, 0, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        step("reg_zero", 0, 0, 4);
        drive(0, 1, 6, 6, 0, 1, 0, 1, 6, 1, 1, 0, 0);
        step("jtype_flush", 0, 1, 4);
        drive(0, 0, 6, 6, 1, 0, 0, 0, 6, 1, 1, 0, 0);
        step("invalid_id", 0, 0, 4);
        // taken beq behind a load: flush deferred past both stall cycles
        drive(0, 1, 5, 8, 0, 0, 1, 1, 5, 1, 1, 0, 0);
        step("taken_c0", 1, 0, 4);
        drive(0, 1, 5, 8, 0, 0, 1, 1, 0, 0, 0, 5, 1);
        step("taken_c1", 1, 0, 5);
        drive(0, 1, 5, 8, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step("taken_c2", 0, 1, 6);
        drive(0, 1, 9, 10, 0, 0, 1, 0, 0, 0, 0, 10, 1);
        step("memld_br", 1, 0, 6);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("memld_done", 0, 0, 7);
        // reset coinciding with the first cycle of a two-cycle stall
        drive(1, 1, 3, 9, 0, 0, 1, 0, 3, 1, 1, 0, 0);
        step("rst_first", 0, 0, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_first_after", 0, 0, 0);
        // reset landing in the STALL state itself
        drive(0, 1, 3, 9, 0, 0, 1, 0, 3, 1, 1, 0, 0);
        step("rst_mid_c0", 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_mid_c1", 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_mid_after", 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
